// File: rtl/aes_round_sequencer.sv
// Iterative AES encryption controller: owns the state register and round counter and steps an
// external round datapath once per clock. Optional block counter is enabled with AES_SEQ_PERF_EN.
module aes_round_sequencer #(
  parameter int NR = 10,
  parameter int DW = 128
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          busy,
  output logic [3:0]    rk_idx,
  input  logic [DW-1:0] rk_data,
  output logic [DW-1:0] dp_state,
  output logic          dp_enable,
  output logic          dp_final,
  input  logic [DW-1:0] dp_result
`ifdef AES_SEQ_PERF_EN
  ,
  output logic [31:0]   blk_count,
  output logic [3:0]    round_cnt
`endif
);

  if (DW != 128) begin : g_dw_check
    $error("aes_round_sequencer: DW must be 128");
  end
  if (NR < 1 || NR > 14) begin : g_nr_check
    $error("aes_round_sequencer: NR must be in 1..14");
  end

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ROUND = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [3:0] NR_L    = 4'(NR);

  logic [1:0]    fsm;
  logic [DW-1:0] state_reg;
  logic [3:0]    round;
  logic          accept;
  logic          out_fire;

  assign accept   = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm       <= S_IDLE;
      state_reg <= '0;
      round     <= '0;
    end else begin
      case (fsm)
        S_IDLE: begin
          if (accept) begin
            state_reg <= in_data ^ rk_data;
            round     <= 4'd1;
            fsm       <= S_ROUND;
          end
        end
        S_ROUND: begin
          state_reg <= dp_result;
          if (round == NR_L) begin
            fsm <= S_DONE;
          end else begin
            round <= round + 4'd1;
          end
        end
        S_DONE: begin
          // Ciphertext stays in state_reg after the handshake; only the counter clears.
          if (out_fire) begin
            fsm   <= S_IDLE;
            round <= '0;
          end
        end
        default: fsm <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    // NOTE: defaults first so every path assigns every output and no latch is inferred.
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    rk_idx    = '0;
    dp_enable = 1'b0;
    dp_final  = 1'b0;
    case (fsm)
      S_IDLE: in_ready = 1'b1;
      S_ROUND: begin
        busy      = 1'b1;
        dp_enable = 1'b1;
        rk_idx    = round;
        dp_final  = (round == NR_L);
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
      end
      default: ;
    endcase
  end

  assign out_data = state_reg;
  assign dp_state = state_reg;

`ifdef AES_SEQ_PERF_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      blk_count <= '0;
    end else if (out_fire) begin
      blk_count <= blk_count + 32'd1;
    end
  end

  assign round_cnt = round;
`endif

  a_hold_output: assert property (@(posedge clk) disable iff (rst)
    (out_valid && !out_ready) |=> (out_valid && $stable(out_data)));
  a_round_bound: assert property (@(posedge clk) round <= NR_L);

endmodule

// File: tb/tb_aes_round_sequencer.sv
// Scoreboard bench for aes_round_sequencer: AES-128 (NR=10) and AES-256 (NR=14) instances, each
// driven through a behavioural AES round datapath and expanded-key store supplied here.
module tb_aes_round_sequencer;

  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CT_128  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] CT_256  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [255:0] KEY_128 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
  localparam logic [255:0] KEY_256 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cycle_count = 0;
  always @(posedge clk) cycle_count <= cycle_count + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h, wanted %h", name, act, want);
    end
  endtask

  // ---------------- AES reference pieces ----------------
  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] inv;
    inv = 8'h00;
    for (int y = 1; y < 256; y++) begin
      if (gmul(x, 8'(y)) == 8'h01) inv = 8'(y);
    end
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  function automatic logic [31:0] subword(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic fin);
    logic [7:0] b [16];
    logic [7:0] t [16];
    logic [7:0] a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
    for (int c = 0; c < 4; c++)
      for (int rr = 0; rr < 4; rr++) t[4*c+rr] = b[4*((c+rr)%4)+rr];
    if (!fin) begin
      for (int c = 0; c < 4; c++) begin
        a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
        t[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
        t[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
        t[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
        t[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = t[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] round_key(input logic [255:0] key, input int nk, input int nr,
                                             input int idx);
    logic [31:0] w [60];
    logic [31:0] t;
    logic [7:0]  rcon;
    rcon = 8'h01;
    for (int i = 0; i < nk; i++) w[i] = key[255-32*i -: 32];
    for (int i = nk; i < 4*(nr+1); i++) begin
      t = w[i-1];
      if (i % nk == 0) begin
        t = subword({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
        rcon = xt(rcon);
      end else if (nk > 6 && i % nk == 4) begin
        t = subword(t);
      end
      w[i] = w[i-nk] ^ t;
    end
    return {w[4*idx], w[4*idx+1], w[4*idx+2], w[4*idx+3]};
  endfunction

  logic [127:0] ks_a [16];
  logic [127:0] ks_b [16];

  function automatic logic [127:0] aes128_ref(input logic [127:0] pt);
    logic [127:0] s;
    s = pt ^ ks_a[0];
    for (int r = 1; r <= 10; r++) s = aes_round(s, ks_a[r], r == 10);
    return s;
  endfunction

  // ---------------- DUT A: NR=10 ----------------
  logic         in_valid_a = 1'b0, out_ready_a = 1'b0;
  logic [127:0] in_data_a = '0;
  logic         in_ready_a, out_valid_a, busy_a, dp_enable_a, dp_final_a;
  logic [3:0]   rk_idx_a;
  logic [127:0] out_data_a, rk_data_a, dp_state_a, dp_result_a;
`ifdef AES_SEQ_PERF_EN
  logic [31:0]  blk_count_a, blk_count_b;
  logic [3:0]   round_cnt_a, round_cnt_b;
`endif

  assign rk_data_a = ks_a[rk_idx_a];
  always_comb dp_result_a = aes_round(dp_state_a, rk_data_a, dp_final_a);

  aes_round_sequencer #(.NR(10), .DW(128)) dut_a (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
    .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
    .busy(busy_a), .rk_idx(rk_idx_a), .rk_data(rk_data_a),
    .dp_state(dp_state_a), .dp_enable(dp_enable_a), .dp_final(dp_final_a),
    .dp_result(dp_result_a)
`ifdef AES_SEQ_PERF_EN
    , .blk_count(blk_count_a), .round_cnt(round_cnt_a)
`endif
  );

  // ---------------- DUT B: NR=14 ----------------
  logic         in_valid_b = 1'b0, out_ready_b = 1'b0;
  logic [127:0] in_data_b = '0;
  logic         in_ready_b, out_valid_b, busy_b, dp_enable_b, dp_final_b;
  logic [3:0]   rk_idx_b;
  logic [127:0] out_data_b, rk_data_b, dp_state_b, dp_result_b;

  assign rk_data_b = ks_b[rk_idx_b];
  always_comb dp_result_b = aes_round(dp_state_b, rk_data_b, dp_final_b);

  aes_round_sequencer #(.NR(14), .DW(128)) dut_b (
    .clk(clk), .rst(rst),
    .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
    .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
    .busy(busy_b), .rk_idx(rk_idx_b), .rk_data(rk_data_b),
    .dp_state(dp_state_b), .dp_enable(dp_enable_b), .dp_final(dp_final_b),
    .dp_result(dp_result_b)
`ifdef AES_SEQ_PERF_EN
    , .blk_count(blk_count_b), .round_cnt(round_cnt_b)
`endif
  );

  // ---------------- Scoreboards ----------------
  logic [127:0] exp_a [$];
  logic [127:0] exp_b [$];

  always @(negedge clk) begin
    if (!rst && out_valid_a && out_ready_a) begin
      if (exp_a.size() == 0) begin
        checks++; errors++;
        $display("FAIL ct_a: unexpected output %h, nothing queued", out_data_a);
      end else begin
        check("ct_a", out_data_a, exp_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && out_valid_b && out_ready_b) begin
      if (exp_b.size() == 0) begin
        checks++; errors++;
        $display("FAIL ct_b: unexpected output %h, nothing queued", out_data_b);
      end else begin
        check("ct_b", out_data_b, exp_b.pop_front());
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic drain_a(input string name);
    for (int i = 0; i < 60 && exp_a.size() != 0; i++) @(negedge clk);
    check(name, 128'(exp_a.size()), 128'(0));
  endtask

  // ---------------- Stimulus ----------------
  logic [127:0] pts [3];
  logic [127:0] cts [3];
  int n_acc, last_acc;

  initial begin
    for (int i = 0; i < 16; i++) begin
      ks_a[i] = (i <= 10) ? round_key(KEY_128, 4, 10, i) : '0;
      ks_b[i] = (i <= 14) ? round_key(KEY_256, 8, 14, i) : '0;
    end
    pts[0] = PT_FIPS;                               cts[0] = CT_128;
    pts[1] = 128'h0;                                cts[1] = aes128_ref(pts[1]);
    pts[2] = 128'hffeeddccbbaa99887766554433221100; cts[2] = aes128_ref(pts[2]);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready_a), 128'(1));
    check("rst_out_valid", 128'(out_valid_a), 128'(0));
    check("rst_busy", 128'(busy_a), 128'(0));
    check("rst_rk_idx", 128'(rk_idx_a), 128'(0));
    check("rst_dp_enable", 128'(dp_enable_a), 128'(0));
    check("rst_dp_final", 128'(dp_final_a), 128'(0));
    check("rst_out_data", out_data_a, 128'h0);
    check("rst_dp_state", dp_state_a, 128'h0);
    check("rst_b_in_ready", 128'(in_ready_b), 128'(1));
`ifdef AES_SEQ_PERF_EN
    check("rst_blk_count", 128'(blk_count_a), 128'(0));
`endif
    @(posedge clk); #1;
    rst = 1'b0;

    // FIPS-197 AES-128 with sequencing and latency
    in_valid_a = 1'b1; in_data_a = PT_FIPS;
    exp_a.push_back(CT_128);
    @(negedge clk);
    check("idle_rk_idx", 128'(rk_idx_a), 128'(0));
    check("idle_in_ready", 128'(in_ready_a), 128'(1));
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      check($sformatf("rk_idx_r%0d", k), 128'(rk_idx_a), 128'(k));
      check($sformatf("dp_en_r%0d", k), 128'(dp_enable_a), 128'(1));
      check($sformatf("dp_final_r%0d", k), 128'(dp_final_a), 128'(k == 10));
      check($sformatf("in_ready_r%0d", k), 128'(in_ready_a), 128'(0));
      check($sformatf("out_valid_r%0d", k), 128'(out_valid_a), 128'(0));
`ifdef AES_SEQ_PERF_EN
      check($sformatf("round_cnt_r%0d", k), 128'(round_cnt_a), 128'(k));
`endif
    end

    // Backpressure: five cycles held in DONE with ignored in_valid
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_out_valid", 128'(out_valid_a), 128'(1));
      check("bp_out_data", out_data_a, CT_128);
      check("bp_dp_enable", 128'(dp_enable_a), 128'(0));
      check("bp_in_ready", 128'(in_ready_a), 128'(0));
      check("bp_rk_idx", 128'(rk_idx_a), 128'(0));
      @(posedge clk); #1;
      in_valid_a = 1'b1; in_data_a = 128'hdeadbeef;
    end
    in_valid_a = 1'b0;
    out_ready_a = 1'b1;
    @(posedge clk); #1;
    out_ready_a = 1'b0;
    @(negedge clk);
    check("post_hs_in_ready", 128'(in_ready_a), 128'(1));
    check("post_hs_out_valid", 128'(out_valid_a), 128'(0));
    check("post_hs_busy", 128'(busy_a), 128'(0));
    check("post_hs_retained", out_data_a, CT_128);
    check("queue_after_fips", 128'(exp_a.size()), 128'(0));

    // Reset mid-operation at rk_idx=4
    @(posedge clk); #1;
    in_valid_a = 1'b1; in_data_a = pts[2];
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    check("mid_rk_idx", 128'(rk_idx_a), 128'(4));
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_in_ready", 128'(in_ready_a), 128'(1));
    check("mid_out_valid", 128'(out_valid_a), 128'(0));
    check("mid_out_data", out_data_a, 128'h0);
    check("mid_busy", 128'(busy_a), 128'(0));
    repeat (14) @(negedge clk);
    check("mid_no_output", 128'(out_valid_a), 128'(0));

    // Block after reset
    @(posedge clk); #1;
    out_ready_a = 1'b1;
    in_valid_a = 1'b1; in_data_a = PT_FIPS;
    exp_a.push_back(CT_128);
    @(posedge clk); #1;
    in_valid_a = 1'b0;
    drain_a("drain_post_reset");

    // Back-to-back, after a clean reset
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready_a = 1'b1;
    in_valid_a = 1'b1; in_data_a = pts[0];
    n_acc = 0; last_acc = 0;
    for (int c = 0; c < 100 && n_acc < 3; c++) begin
      @(negedge clk);
      if (in_ready_a) begin
        exp_a.push_back(cts[n_acc]);
        if (n_acc > 0) check("b2b_gap", 128'(cycle_count - last_acc), 128'(12));
        last_acc = cycle_count;
        n_acc++;
        @(posedge clk); #1;
        if (n_acc < 3) in_data_a = pts[n_acc];
        else in_valid_a = 1'b0;
      end
    end
    in_valid_a = 1'b0;
    check("b2b_accepted", 128'(n_acc), 128'(3));
    drain_a("drain_b2b");
`ifdef AES_SEQ_PERF_EN
    @(negedge clk);
    check("blk_count", 128'(blk_count_a), 128'(3));
`endif

    // AES-256 on the NR=14 instance
    @(posedge clk); #1;
    out_ready_b = 1'b1;
    in_valid_b = 1'b1; in_data_b = PT_FIPS;
    exp_b.push_back(CT_256);
    @(negedge clk);
    check("b_idle_in_ready", 128'(in_ready_b), 128'(1));
    @(posedge clk); #1;
    in_valid_b = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      check($sformatf("b_rk_idx_r%0d", k), 128'(rk_idx_b), 128'(k));
      check($sformatf("b_dp_final_r%0d", k), 128'(dp_final_b), 128'(k == 14));
      check($sformatf("b_out_valid_r%0d", k), 128'(out_valid_b), 128'(0));
    end
    @(negedge clk);
    check("b_latency14", 128'(out_valid_b), 128'(1));
    for (int i = 0; i < 20 && exp_b.size() != 0; i++) @(negedge clk);
    check("drain_b", 128'(exp_b.size()), 128'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/aes_round_sequencer.md
Name: aes_round_sequencer

Overview:
- Iterative AES encryption controller. Owns the 128-bit state register and round counter.
- Drives one shared external round datapath (subBytes -> shiftRows -> mixColumns -> addRoundKey) once per clock.
- Fetches round keys by index from an external expanded-key store.
- Sits between the block-input stream and the ciphertext-output stream, with valid/ready handshakes on both sides.

Parameters:
- NR, 10, number of rounds (10/12/14 for AES-128/192/256; legal range 1..14).
- DW, 128, state/data width (fixed at 128; elaborate-time error otherwise).

Ports:
- clk  input  1  clock; all logic on rising edge.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  plaintext block valid.
- in_ready  output  1  sequencer can accept a block.
- in_data  input  DW  plaintext block.
- out_valid  output  1  ciphertext valid.
- out_ready  input  1  downstream accepts ciphertext.
- out_data  output  DW  ciphertext (state register).
- busy  output  1  high in ROUND or DONE.
- rk_idx  output  4  round-key index requested this cycle.
- rk_data  input  DW  round key for rk_idx; combinational, same cycle.
- dp_state  output  DW  current state fed to the round datapath.
- dp_enable  output  1  datapath round enable (drives shiftRows/mixColumns enables).
- dp_final  output  1  final round; datapath must skip mixColumns.
- dp_result  input  DW  combinational round result, including addRoundKey with rk_data.

Behaviour:

Reset:
- rst sampled high forces state IDLE, state_reg=0 and round=0.
- All outputs then read: in_ready=1, out_valid=0, busy=0, rk_idx=0, dp_enable=0, dp_final=0, out_data=0.
- rst has priority over every other event, including mid-ROUND and DONE. An in-flight block is discarded; no partial output.

IDLE:
- in_ready=1, rk_idx=0, dp_enable=0.
- On in_valid&&in_ready: state_reg<=in_data^rk_data (initial addRoundKey, key 0), round<=1, go to ROUND.

ROUND:
- in_ready=0, dp_enable=1, rk_idx=round, dp_final=(round==NR).
- Each edge: state_reg<=dp_result and round<=round+1.
- When round==NR at the edge: go to DONE. round is not incremented past NR.

DONE:
- out_valid=1, out_data=state_reg, dp_enable=0, rk_idx=0, in_ready=0.
- Holds until out_ready. On out_valid&&out_ready: go to IDLE; state_reg retained, round<=0.

General rules:
- out_data is stable while out_valid=1 and out_ready=0.
- dp_state always equals state_reg.
- Latency: out_valid rises exactly NR edges after the accepting edge.
- Throughput: one block per NR+2 cycles (accept, NR rounds, one-cycle IDLE gap). A new block is never accepted in the same cycle as output handshake.
- in_data and in_valid are ignored outside IDLE; there is no queuing.
- round width is 4 bits. No wrap is possible because round is bounded by NR≤14.

Optional Feature:
- Macro AES_SEQ_PERF_EN.
- When defined:
  - Extra output port blk_count, 32 bits.
  - Increments by 1 on each output handshake (out_valid&&out_ready).
  - Reset to 0 by rst. Wraps from 0xFFFFFFFF to 0.
  - Also exports round_cnt[3:0] = internal round counter.
- When undefined: neither port exists and no counter logic is synthesised. Core behaviour is identical.

Test Plan:
- FIPS-197 AES-128 vector, NR=10, bench supplies model datapath and expanded key for key 000102030405060708090a0b0c0d0e0f. Drive in_data=00112233445566778899aabbccddeeff -> out_valid exactly 10 edges after accept; out_data=69c4e0d86a7b0430d8cdb78070b4c55a; dp_final high only in the cycle where rk_idx=10.
- Sequencing check -> rk_idx reads 0 in IDLE, then 1,2,…,10 on consecutive ROUND cycles; dp_enable high for exactly 10 cycles; in_ready=0 throughout.
- Backpressure: out_ready=0 for 5 cycles after DONE -> out_valid and out_data held constant; in_valid pulses ignored. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset mid-operation: assert rst while rk_idx=4 -> next cycle IDLE with in_ready=1, out_valid=0, out_data=0. A subsequent block still produces the correct ciphertext.
- Back-to-back: in_valid held high with 3 blocks, out_ready=1 -> blocks accepted every 12 cycles; three correct ciphertexts in order. With AES_SEQ_PERF_EN, blk_count=3 afterwards.
- NR=14 build with an AES-256 vector (key 000102…1f, plaintext 00112233…ff) -> out_data=8ea2b7ca516745bfeafc49904b496089; latency 14 edges.
